// File: rtl/ppu_types_pkg.sv
// ppu_types_pkg: shared PPU pixel/shade types and LCD geometry.
// Revision: 1.0 - initial release
`default_nettype none

package ppu_types_pkg;

  localparam int LCD_WIDTH = 160;

  typedef logic [1:0] shade_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] color;
  } pixel_t;

  // BGP holds four 2-bit shades, indexed by the pixel colour number.
  function automatic shade_t map_shade(input logic [7:0] bgp, input logic [1:0] color);
    shade_t s;
    case (color)
      2'd0:    s = bgp[1:0];
      2'd1:    s = bgp[3:2];
      2'd2:    s = bgp[5:4];
      default: s = bgp[7:6];
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bg_pixel_shifter_if.sv
// bg_pixel_shifter_if: fetcher -> pixel FIFO push bus with FIFO status.
// Revision: 1.0 - initial release
`default_nettype none

interface bg_pixel_shifter_if;
  import ppu_types_pkg::*;

  logic   fifo_write_en;
  pixel_t fifo_write_data;
  logic   fifo_empty;
  logic   fifo_full;
  logic   overflow;

  modport master (
    output fifo_write_en, fifo_write_data,
    input  fifo_empty, fifo_full, overflow
  );

  modport slave (
    input  fifo_write_en, fifo_write_data,
    output fifo_empty, fifo_full, overflow
  );

endinterface

`default_nettype wire

// File: rtl/bg_pixel_shifter_fifo.sv
// bg_pixel_fifo: DEPTH-entry pixel FIFO with flush and overflow pulse.
// Revision: 1.0 - initial release
`default_nettype none

module bg_pixel_fifo
  import ppu_types_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire logic   clk,
  input  wire logic   reset,
  input  wire logic   flush,
  input  wire logic   wr_en,
  input  wire pixel_t wr_data,
  input  wire logic   rd_en,
  output pixel_t      rd_data,
  output logic        empty,
  output logic        full,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL_CNT = (AW + 1)'(DEPTH);

  pixel_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_push;
  logic          w_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == c_FULL_CNT);
  assign overflow = r_overflow;
  assign rd_data  = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted only if a pop frees a slot the same cycle.
  assign w_pop  = rd_en && !empty && !flush;
  assign w_push = wr_en && (!full || w_pop) && !flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && full && !w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/bg_pixel_shifter.sv
// bg_pixel_shifter: pops BG pixels per mode-3 dot, drops SCX fine-scroll pixels,
// maps colours through BGP and emits one LCD pixel with its X coordinate.
// Revision: 1.0 - initial release
`default_nettype none

module bg_pixel_shifter
  import ppu_types_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int LINE_WIDTH = LCD_WIDTH
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         line_start,
  input  wire logic         dot_en,
  input  wire logic [2:0]   scx_fine,
  input  wire logic         bg_enable,
  input  wire logic [7:0]   bgp,
  bg_pixel_shifter_if.slave fifo_if,
  output logic              lcd_valid,
  output shade_t            lcd_shade,
  output logic [7:0]        lcd_x,
  output logic              line_done
);

  localparam logic [7:0] c_LAST_X = 8'(LINE_WIDTH - 1);

  logic       r_active;
  logic [7:0] r_x_cnt;
  logic [2:0] r_discard;
  logic       r_lcd_valid;
  shade_t     r_lcd_shade;
  logic [7:0] r_lcd_x;
  logic       r_line_done;

  pixel_t     w_rd_data;
  logic       w_empty;
  logic       w_full;
  logic       w_overflow;
  logic       w_pop;
  shade_t     w_shade;

  bg_pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (line_start),
    .wr_en    (fifo_if.fifo_write_en),
    .wr_data  (fifo_if.fifo_write_data),
    .rd_en    (w_pop),
    .rd_data  (w_rd_data),
    .empty    (w_empty),
    .full     (w_full),
    .overflow (w_overflow)
  );

  assign fifo_if.fifo_empty = w_empty;
  assign fifo_if.fifo_full  = w_full;
  assign fifo_if.overflow   = w_overflow;

  assign w_pop   = dot_en && r_active && !w_empty && !line_start;
  // Pixels flagged invalid still consume a dot and an X position, but show shade 0.
  assign w_shade = (bg_enable && w_rd_data.valid) ? map_shade(bgp, w_rd_data.color) : 2'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_active    <= 1'b0;
      r_x_cnt     <= '0;
      r_discard   <= '0;
      r_lcd_valid <= 1'b0;
      r_lcd_shade <= '0;
      r_lcd_x     <= '0;
      r_line_done <= 1'b0;
    end else if (line_start) begin
      r_active    <= 1'b1;
      r_x_cnt     <= '0;
      r_discard   <= scx_fine;
      r_lcd_valid <= 1'b0;
      r_line_done <= 1'b0;
    end else begin
      r_lcd_valid <= 1'b0;
      r_line_done <= 1'b0;
      if (w_pop) begin
        if (r_discard != 3'd0) begin
          r_discard <= r_discard - 3'd1;
        end else begin
          r_lcd_valid <= 1'b1;
          r_lcd_shade <= w_shade;
          r_lcd_x     <= r_x_cnt;
          r_x_cnt     <= r_x_cnt + 8'd1;
          if (r_x_cnt == c_LAST_X) begin
            r_active    <= 1'b0;
            r_line_done <= 1'b1;
          end
        end
      end
    end
  end

  assign lcd_valid = r_lcd_valid;
  assign lcd_shade = r_lcd_shade;
  assign lcd_x     = r_lcd_x;
  assign line_done = r_line_done;

endmodule

`default_nettype wire

// File: tb/tb_bg_pixel_shifter.sv
// tb_bg_pixel_shifter: scoreboard bench for bg_pixel_shifter.
// Revision: 1.0 - initial release
`default_nettype none

module tb_bg_pixel_shifter;
  import ppu_types_pkg::*;

  logic       clk;
  logic       reset;
  logic       line_start;
  logic       dot_en;
  logic [2:0] scx_fine;
  logic       bg_enable;
  logic [7:0] bgp;
  logic       lcd_valid;
  shade_t     lcd_shade;
  logic [7:0] lcd_x;
  logic       line_done;

  bg_pixel_shifter_if u_if ();

  bg_pixel_shifter #(.DEPTH(16), .LINE_WIDTH(160)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .dot_en     (dot_en),
    .scx_fine   (scx_fine),
    .bg_enable  (bg_enable),
    .bgp        (bgp),
    .fifo_if    (u_if),
    .lcd_valid  (lcd_valid),
    .lcd_shade  (lcd_shade),
    .lcd_x      (lcd_x),
    .line_done  (line_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;
  int n_stray;
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  logic [10:0] o;
  logic [10:0] e;

  // Reference model state: {line_done, shade, x} per emitted pixel
  logic [7:0] m_x;
  logic [2:0] m_disc;
  bit         m_active;

  function automatic logic [1:0] exp_shade(input pixel_t p);
    logic [7:0] t;
    t = bgp >> (2 * int'(p.color));
    return (bg_enable && p.valid) ? t[1:0] : 2'd0;
  endfunction

  task automatic model_line_start();
    m_x      = 8'd0;
    m_disc   = scx_fine;
    m_active = 1'b1;
  endtask

  task automatic model_push(input pixel_t p);
    if (m_active) begin
      if (m_disc != 3'd0) begin
        m_disc = m_disc - 3'd1;
      end else begin
        exp_q.push_back({(m_x == 8'd159), exp_shade(p), m_x});
        if (m_x == 8'd159) m_active = 1'b0;
        m_x = m_x + 8'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (lcd_valid) obs_q.push_back({line_done, lcd_shade, lcd_x});
    else if (line_done) n_stray++;
  endtask

  task automatic push_px(input pixel_t p, input bit rec);
    u_if.fifo_write_en   = 1'b1;
    u_if.fifo_write_data = p;
    tick();
    u_if.fifo_write_en   = 1'b0;
    if (rec) model_push(p);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_line(input logic [2:0] scx);
    scx_fine   = scx;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    model_line_start();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drain(2);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_run++;
      if ({lcd_valid, lcd_shade, lcd_x, line_done, u_if.overflow, u_if.fifo_full, u_if.fifo_empty}
          !== 15'b1) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %b expected %b", i,
                 {lcd_valid, lcd_shade, lcd_x, line_done, u_if.overflow, u_if.fifo_full,
                  u_if.fifo_empty}, 15'b1);
      end
    end
  endtask

  task automatic test_basic();
    obs_q.delete(); exp_q.delete();
    bgp = 8'hE4; bg_enable = 1'b1; dot_en = 1'b1;
    start_line(3'd0);
    for (int i = 0; i < 8; i++) push_px(pixel_t'({1'b1, 2'(i % 4)}), 1'b1);
    drain(3);
    n_run++;
    if (u_if.fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL basic_empty: got %b expected 1", u_if.fifo_empty);
    end
    n_run++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL basic_px: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_scroll();
    obs_q.delete(); exp_q.delete();
    bgp = 8'hE4; bg_enable = 1'b1; dot_en = 1'b1;
    start_line(3'd5);
    for (int i = 0; i < 8; i++) push_px(pixel_t'({1'b1, 2'(i % 4)}), 1'b1);
    drain(3);
    bg_enable = 1'b0;
    start_line(3'd0);
    for (int i = 0; i < 4; i++) push_px(pixel_t'({1'b1, 2'(i)}), 1'b1);
    drain(3);
    bg_enable = 1'b1;
    start_line(3'd0);
    push_px(pixel_t'({1'b0, 2'd3}), 1'b1);
    push_px(pixel_t'({1'b1, 2'd3}), 1'b1);
    drain(3);
    n_run++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL scroll_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL scroll_px: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_overflow();
    obs_q.delete(); exp_q.delete();
    bgp = 8'h1B; bg_enable = 1'b1; dot_en = 1'b0;
    start_line(3'd0);
    for (int i = 0; i < 16; i++) push_px(pixel_t'({1'b1, 2'(i % 4)}), 1'b1);
    n_run++;
    if ({u_if.fifo_full, u_if.overflow} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_filled: got full/ovf %b expected 10", {u_if.fifo_full, u_if.overflow});
    end
    push_px(pixel_t'({1'b1, 2'd2}), 1'b0);
    n_run++;
    if ({u_if.fifo_full, u_if.overflow} !== 2'b11) begin
      n_fail++; $display("FAIL ovf_pulse: got full/ovf %b expected 11", {u_if.fifo_full, u_if.overflow});
    end
    tick();
    n_run++;
    if ({u_if.fifo_full, u_if.overflow} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_clear: got full/ovf %b expected 10", {u_if.fifo_full, u_if.overflow});
    end
    dot_en = 1'b1;
    push_px(pixel_t'({1'b1, 2'd1}), 1'b1);
    n_run++;
    if ({u_if.fifo_full, u_if.overflow} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_pushpop: got full/ovf %b expected 10", {u_if.fifo_full, u_if.overflow});
    end
    drain(20);
    n_run++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovf_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL ovf_px: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_line_done();
    obs_q.delete(); exp_q.delete();
    n_stray = 0;
    bgp = 8'hE4; bg_enable = 1'b1; dot_en = 1'b1;
    start_line(3'd0);
    for (int i = 0; i < 160; i++) push_px(pixel_t'({1'b1, 2'($urandom_range(0, 3))}), 1'b1);
    for (int i = 0; i < 4; i++) push_px(pixel_t'({1'b1, 2'd3}), 1'b1);
    drain(6);
    n_run++;
    if (n_stray != 0) begin
      n_fail++; $display("FAIL done_stray: got %0d line_done without pixel, expected 0", n_stray);
    end
    n_run++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL done_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL done_px: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_mid_line();
    obs_q.delete(); exp_q.delete();
    bgp = 8'hD2; bg_enable = 1'b1; dot_en = 1'b1;
    start_line(3'd0);
    for (int i = 0; i < 41; i++) push_px(pixel_t'({1'b1, 2'($urandom_range(0, 3))}), 1'b1);
    tick();
    reset = 1'b0;
    tick();
    n_run++;
    if ({lcd_valid, lcd_shade, lcd_x, line_done, u_if.overflow, u_if.fifo_empty} !== 14'b1) begin
      n_fail++;
      $display("FAIL midreset_outs: got %b expected %b",
               {lcd_valid, lcd_shade, lcd_x, line_done, u_if.overflow, u_if.fifo_empty}, 14'b1);
    end
    reset = 1'b1;
    m_active = 1'b0;
    for (int i = 0; i < 3; i++) push_px(pixel_t'({1'b1, 2'd1}), 1'b1);
    drain(2);
    n_run++;
    if (u_if.fifo_empty !== 1'b0) begin
      n_fail++; $display("FAIL midreset_nopop: got empty %b expected 0", u_if.fifo_empty);
    end
    start_line(3'd0);
    for (int i = 0; i < 3; i++) push_px(pixel_t'({1'b1, 2'(i + 1)}), 1'b1);
    drain(2);
    dot_en = 1'b0;
    for (int i = 0; i < 3; i++) push_px(pixel_t'({1'b1, 2'd3}), 1'b0);
    u_if.fifo_write_en   = 1'b1;
    u_if.fifo_write_data = pixel_t'({1'b1, 2'd3});
    start_line(3'd0);
    u_if.fifo_write_en = 1'b0;
    n_run++;
    if ({u_if.fifo_empty, u_if.overflow} !== 2'b10) begin
      n_fail++; $display("FAIL midstart_flush: got empty/ovf %b expected 10", {u_if.fifo_empty, u_if.overflow});
    end
    dot_en = 1'b1;
    push_px(pixel_t'({1'b1, 2'd2}), 1'b1);
    push_px(pixel_t'({1'b1, 2'd0}), 1'b1);
    drain(3);
    n_run++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL mid_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL mid_px: got %h expected %h", o, e); end
    end
  endtask

  initial begin
    n_run = 0; n_fail = 0; n_stray = 0;
    m_x = 8'd0; m_disc = 3'd0; m_active = 1'b0;
    reset = 1'b0; line_start = 1'b0; dot_en = 1'b0; scx_fine = 3'd0;
    bg_enable = 1'b0; bgp = 8'h00;
    u_if.fifo_write_en   = 1'b0;
    u_if.fifo_write_data = '0;
    test_reset();
    test_basic();
    test_scroll();
    test_overflow();
    test_line_done();
    test_mid_line();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
